pc_gen: RTL and testbench

- Parametrised successor to the basic program counter for the 5-stage RISC-V pipeline.
- Generates the IF-stage fetch address with stall hold and EX-stage redirect (branch/jump resolution).
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for next-PC prediction.
- Sits at the head of IF. Outputs drive the instruction memory address and the IF/ID register (pred_taken travels down the pipe for misprediction checking).

---
 rtl/pc_gen.sv | 98 +++++++++
 tb/tb_pc_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - IF-stage program counter with a direct-mapped BTB and 2-bit counters
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            misalign
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // BTB storage; only the valid bits need a reset value
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             hit;
    logic             upd_hit;

    assign idx     = pc_out[IDX_W+1:2];
    assign tag     = pc_out[XLEN-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

    // Lookup reads the pre-update contents, so training is visible one cycle later
    assign hit         = valid_q[idx] && (tag_q[idx] == tag);
    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign pred_taken  = pc_valid && hit && ctr_q[idx][1];
    assign pred_target = target_q[idx];

    // Fetch address sequencing: redirect > stall > predicted-taken > sequential
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out   <= RESET_VECTOR;
            pc_valid <= 1'b0;
            misalign <= 1'b0;
        end else begin
            pc_valid <= 1'b1;
            if (redirect_valid) begin
                pc_out   <= {redirect_pc[XLEN-1:2], 2'b00};
                misalign <= |redirect_pc[1:0];
            end else if (stall) begin
                pc_out   <= pc_out;
                misalign <= misalign;
            end else if (pred_taken) begin
                pc_out   <= pred_target;
                misalign <= 1'b0;
            end else begin
                pc_out   <= pc_out + PC_STEP;
                misalign <= 1'b0;
            end
        end
    end

    // BTB training from resolved branches; independent of stall and redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != 2'd3) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                    end
                    target_q[upd_idx] <= upd_target;
                end else if (ctr_q[upd_idx] != 2'd0) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen against a behavioural fetch/BTB model
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        misalign;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .pc_out(pc_out), .pc_valid(pc_valid), .pred_taken(pred_taken),
        .pred_target(pred_target), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pcv;
        logic        tk;
        logic [31:0] tgt;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: each BTB slot remembers the full word address it was trained on
    logic [31:0] m_pc;
    logic        m_pcv;
    logic        m_mis;
    bit          m_v    [16];
    logic [29:0] m_word [16];
    logic [31:0] m_tgt  [16];
    int          m_ctr  [16];

    function automatic int slot_of(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic bit model_pred(input logic [31:0] a, input logic v);
        int s;
        logic [29:0] w;
        s = slot_of(a);
        w = a[31:2];
        return v && m_v[s] && (m_word[s] == w) && (m_ctr[s] >= 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] rpc,
                        input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                        input logic ut);
        bit          tk;
        logic [31:0] tgt;
        int          s;
        logic [29:0] w;
        exp_t        e;
        reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc;
        upd_valid = uv; upd_pc = upd_pc; upd_pc = upc; upd_target = utgt; upd_taken = ut;
        if (rst) begin
            m_pc = 32'h0; m_pcv = 1'b0; m_mis = 1'b0;
            for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        end else begin
            tk  = model_pred(m_pc, m_pcv);
            tgt = m_tgt[slot_of(m_pc)];
            m_pcv = 1'b1;
            if (rv) begin
                m_pc  = rpc - (rpc % 4);
                m_mis = (rpc % 4) != 0;
            end else if (st) begin
                // hold
            end else if (tk) begin
                m_pc = tgt; m_mis = 1'b0;
            end else begin
                m_pc = m_pc + 32'd4; m_mis = 1'b0;
            end
            if (uv) begin
                s = slot_of(upc);
                w = upc[31:2];
                if (m_v[s] && m_word[s] == w) begin
                    if (ut) begin
                        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                        m_tgt[s] = utgt;
                    end else begin
                        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                    end
                end else if (ut) begin
                    m_v[s] = 1'b1; m_word[s] = w; m_tgt[s] = utgt; m_ctr[s] = 2;
                end
            end
        end
        e.pc  = m_pc;
        e.pcv = m_pcv;
        e.tk  = model_pred(m_pc, m_pcv);
        e.tgt = m_tgt[slot_of(m_pc)];
        e.mis = m_mis;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic redir(input logic [31:0] a);
        step(0, 0, 1, a, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic train(input logic [31:0] a, input logic [31:0] t, input logic tk);
        step(0, 1, 0, 32'h0, 1, a, t, tk);
    endtask

    // Monitor: compares every presented output against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("pc_valid", {31'h0, pc_valid}, {31'h0, e.pcv});
                chk("pred_taken", {31'h0, pred_taken}, {31'h0, e.tk});
                chk("misalign", {31'h0, misalign}, {31'h0, e.mis});
                if (e.tk) chk("pred_target", pred_target, e.tgt);
            end
        end
    end

    initial begin
        upd_pc = 32'h0;
        // Reset then sequential run
        step(1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        idle(4);
        // Stall hold, then redirect overriding stall
        redir(32'h10);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        step(0, 1, 1, 32'h200, 0, 32'h0, 32'h0, 0);
        idle(1);
        // Misaligned redirect
        redir(32'h106);
        idle(2);
        // Train 0x20 -> 0x80 and fetch through it
        train(32'h20, 32'h80, 1);
        redir(32'h18);
        idle(4);
        // Two not-taken updates weaken the counter to 0
        train(32'h20, 32'h80, 0);
        train(32'h20, 32'h80, 0);
        redir(32'h18);
        idle(3);
        // Alias replacement at the same slot
        train(32'h20, 32'h80, 1);
        train(32'h60, 32'h90, 1);
        redir(32'h1c);
        idle(3);
        // Saturation: four taken, one not-taken still predicts taken
        for (int i = 0; i < 4; i++) train(32'h60, 32'hA0, 1);
        train(32'h60, 32'hA0, 0);
        redir(32'h5c);
        idle(3);
        // Address wrap
        redir(32'hFFFF_FFFC);
        idle(2);
        redir(32'hFFFF_FFFE);
        idle(1);
        // Reset mid-operation with a simultaneous update
        train(32'h300, 32'h40, 1);
        redir(32'h300);
        step(1, 0, 0, 32'h0, 1, 32'h300, 32'h44, 1);
        idle(1);
        redir(32'h300);
        redir(32'h60);
        idle(2);
        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic        r_rst, r_st, r_rv, r_uv, r_ut;
            logic [31:0] r_rpc, r_upc, r_tgt;
            r_rst = ($urandom_range(0, 149) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_rv  = ($urandom_range(0, 5) == 0);
            r_rpc = ($urandom_range(0, 9) == 0) ? $urandom : (32'($urandom_range(0, 63)) << 2);
            r_uv  = ($urandom_range(0, 1) == 0);
            r_upc = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
            r_tgt = 32'($urandom_range(0, 127)) << 2;
            r_ut  = ($urandom_range(0, 2) != 0);
            step(r_rst, r_st, r_rv, r_rpc, r_uv, r_upc, r_tgt, r_ut);
        end
        idle(1);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
